// File: rtl/mux_gate_selftest_ctrl.sv
// Purpose: exhaustive 4-vector self-test sequencer for one mux-built 2-input gate.
// Latency: done pulses 4*(SETTLE_CYCLES+1) edges after the start-accepting edge.
// Backpressure: none; start is only sampled in IDLE, requests while busy are dropped.
//
// Ports:
//   clk, rst_n      clock (rising edge) and asynchronous active-low reset
//   start           run request, honoured only when idle
//   expected[3:0]   truth table, bit index = {A,B}; latched at start
//   y_dut           output of the gate under test
//   a_out, b_out    registered drives to gate inputs A and B
//   busy            high from the accepting edge through DONE
//   done            one-cycle completion pulse
//   pass            last completed run had no mismatches
//   fail_mask[3:0]  per-vector mismatch flags of the last/current run
//   err_count[7:0]  saturating mismatch count across runs, only present when
//                   MUX_SELFTEST_ERRCNT_EN is defined; cleared only by reset
module mux_gate_selftest_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned CNT_W         = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] expected,
  input  logic       y_dut,
  output logic       a_out,
  output logic       b_out,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] fail_mask
`ifdef MUX_SELFTEST_ERRCNT_EN
  ,
  output logic [7:0] err_count
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(SETTLE_CYCLES - 1);

  state_t           state_q, state_d;
  logic [1:0]       vec_q, vec_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       exp_q, exp_d;
  logic [3:0]       mask_q, mask_d;
  logic             pass_q, pass_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             mismatch;

  always_comb begin
    state_d  = state_q;
    vec_d    = vec_q;
    cnt_d    = cnt_q;
    exp_d    = exp_q;
    mask_d   = mask_q;
    pass_d   = pass_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    mismatch = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          exp_d   = expected;
          vec_d   = 2'd0;
          mask_d  = 4'b0000;
          pass_d  = 1'b0;
          cnt_d   = CNT_RELOAD;
          busy_d  = 1'b1;
          state_d = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (cnt_q == '0) begin
          state_d = ST_SAMPLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_SAMPLE: begin
        mismatch = (y_dut != exp_q[vec_q]);
        if (mismatch) begin
          mask_d[vec_q] = 1'b1;
        end
        if (vec_q == 2'd3) begin
          // done and pass are registered on the edge entering DONE so they
          // are visible during the DONE cycle, using the fully updated mask.
          state_d = ST_DONE;
          done_d  = 1'b1;
          pass_d  = (mask_d == 4'b0000);
        end else begin
          vec_d   = vec_q + 2'd1;
          cnt_d   = CNT_RELOAD;
          state_d = ST_SETTLE;
        end
      end
      ST_DONE: begin
        // vec stays at 3 so the gate inputs rest at 1/1 until the next run.
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      vec_q   <= 2'd0;
      cnt_q   <= '0;
      exp_q   <= 4'b0000;
      mask_q  <= 4'b0000;
      pass_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      exp_q   <= exp_d;
      mask_q  <= mask_d;
      pass_q  <= pass_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // The vector index register directly drives the gate inputs: A is the MSB.
  assign a_out     = vec_q[1];
  assign b_out     = vec_q[0];
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign fail_mask = mask_q;

`ifdef MUX_SELFTEST_ERRCNT_EN
  logic [7:0] err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 8'd0;
    end else if ((state_q == ST_SAMPLE) && mismatch && (err_q != 8'hFF)) begin
      err_q <= err_q + 8'd1;
    end
  end

  assign err_count = err_q;
`endif

endmodule

// File: doc/mux_gate_selftest_ctrl.md
Name: mux_gate_selftest_ctrl

Overview:
Sequencing controller that exhaustively exercises one 2-input gate built from a 2x1 mux (OR, AND, XOR, etc.). On a start pulse it drives the gate's A/B inputs through 00, 01, 10, 11 and waits a settle time per vector. It then samples the gate output Y and compares it against a 4-bit expected truth table. It sits beside the gate-under-test and reports per-vector mismatches and an overall pass flag.

Parameters:
SETTLE_CYCLES, 2, cycles spent in SETTLE per vector before sampling; legal range 1..15.
CNT_W, 4, width of the settle counter; must hold SETTLE_CYCLES.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  run request; sampled only in IDLE.
expected  input  4  truth table; bit index = {A,B} (2*A+B); OR = 4'b1110, AND = 4'b1000.
y_dut  input  1  output Y of the mux-built gate under test.
a_out  output  1  registered drive to gate input A.
b_out  output  1  registered drive to gate input B.
busy  output  1  high from the edge that accepts start through DONE inclusive.
done  output  1  one-cycle pulse in DONE state.
pass  output  1  1 when last completed run had fail_mask==0; held until next accepted start.
fail_mask  output  4  bit i set if vector i mismatched in the last/current run.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, a_out=0, b_out=0, busy=0, done=0, pass=0, fail_mask=0, vec=0, counter=0, latched table=0.
- States: IDLE, SETTLE, SAMPLE, DONE; all outputs registered.
- IDLE + start=1 at edge: latch expected into exp_q, vec=0, a_out/b_out=0/0, fail_mask=0, pass=0, cnt=SETTLE_CYCLES-1, busy=1, go SETTLE. start=0: stay.
- SETTLE: cnt==0 -> SAMPLE, else cnt--. Lasts exactly SETTLE_CYCLES cycles.
- SAMPLE (1 cycle): if y_dut != exp_q[vec], set fail_mask[vec].
  - vec<3: vec++, a_out/b_out = new vec bits, reload cnt, go SETTLE.
  - vec==3: go DONE.
- DONE (1 cycle): done=1, pass=(final fail_mask==0), then IDLE with busy=0 and done=0.
- Latency: done high after edge 4*(SETTLE_CYCLES+1) counted from the start-accepting edge; 12 for the default.
- a_out/b_out hold their value through SETTLE and SAMPLE, and hold 1/1 after completion until the next start.
- Boundary conditions:
  - start while busy (SETTLE/SAMPLE/DONE) is ignored; no restart, no queueing.
  - expected changes mid-run are ignored; only exp_q is used.
  - start held high continuously starts a new run on the first IDLE cycle after DONE.
  - rst_n asserted mid-run aborts immediately to reset values; no done pulse.
  - vec is 2 bits and never wraps within a run; terminal detection is vec==3 in SAMPLE.

Optional Feature:
Macro MUX_SELFTEST_ERRCNT_EN.
- Defined: extra output err_count[7:0], cleared only by reset. In each SAMPLE with a mismatch it increments by 1, saturating at 255. It is not cleared by start, so it accumulates across runs.
- Undefined: no err_count port and no counter logic; all other behaviour is identical.

Test Plan:
1. expected=4'b1110, correct OR gate, SETTLE_CYCLES=2, one start pulse -> a_out/b_out sequence 00,01,10,11 (3 cycles each); done at edge 12; fail_mask=0000; pass=1.
2. expected=4'b1000 (AND) against an OR gate -> fail_mask=4'b0110; pass=0; done pulses exactly one cycle.
3. Mid-run (during vector 1), pulse start again and change expected to 4'b0000 -> both ignored; result identical to scenario 1; busy stays high continuously.
4. Assert rst_n=0 during vector 2 SETTLE -> all outputs return to reset values asynchronously; no done. After release, a fresh start completes with pass=1.
5. SETTLE_CYCLES=3 -> each vector applied 4 cycles; done at edge 16; y_dut change applied only during settle still sampled correctly.
6. With MUX_SELFTEST_ERRCNT_EN, run scenario 2 twice -> err_count=4. Preload via 127 failing runs (4 errors each) -> err_count saturates at 255, no wrap.
